morse_sender: RTL and testbench
===============================

MORSE_SENDER -- requirements
Module: morse_sender

Interface
REQ-001 Parameter CLK_DIV, default 25_000_000: clock cycles per Morse time unit; legal range >= 1.
REQ-002 Parameter GAP_UNITS, default 3: low units appended after each letter; legal range 1..7.
REQ-003 Port ClockIn, input, 1: single clock for all state.
REQ-004 Port Reset, input, 1: synchronous, active-high reset, sampled on ClockIn rising edge.
REQ-005 Port Start, input, 1: level request to send the letter on Letter.
REQ-006 Port Letter, input, 5: letter index, 0=A .. 25=Z.
REQ-007 Port DotDashOut, output, 1: Morse waveform, 1=tone.
REQ-008 Port NewBitOut, output, 1: one-cycle pulse at each unit boundary while Busy.
REQ-009 Port Busy, output, 1: high while a letter (incl. trailing gap) is being sent.
REQ-010 Port Done, output, 1: one-cycle pulse at completion of a letter.
REQ-011 Port Err, output, 1: one-cycle pulse when a Start is rejected for Letter > 25.

Function
REQ-012 Encoding: dot = 1 unit high, dash = 3 units high, intra-letter gap = 1 unit low; pattern stored MSB-first, left-aligned in MAX_CODE_W bits with length LEN (1..13 units, no trailing gap).
REQ-013 FSM states: IDLE, SEND, GAP, DONE.
REQ-014 IDLE: Start=1 with Letter<=25 loads pattern/LEN, zeroes the unit divider, and moves to SEND; Busy and DotDashOut (= pattern MSB) take effect the next cycle.
REQ-015 IDLE: Start=1 with Letter>25 keeps IDLE and pulses Err the next cycle; Busy stays 0.
REQ-016 SEND: each unit lasts exactly CLK_DIV cycles; at the last cycle of a unit, NewBitOut=1, the pattern shifts left by 1, and the unit count decrements; after LEN units the FSM enters GAP.
REQ-017 GAP: DotDashOut=0 for GAP_UNITS*CLK_DIV cycles, with NewBitOut pulsing at each unit end; then DONE.
REQ-018 DONE: lasts one cycle, with Done=1, Busy=0, DotDashOut=0; the FSM returns to IDLE unconditionally.
REQ-019 Total Busy time per letter = (LEN+GAP_UNITS)*CLK_DIV cycles exactly.
REQ-020 Start and Letter are ignored while Busy or in DONE; Letter is sampled only on acceptance.
REQ-021 Start held high re-triggers in IDLE, giving back-to-back letters with exactly one idle cycle between Done and the next Busy.
REQ-022 The divider counts down from CLK_DIV-1 to 0 and reloads; with CLK_DIV=1 NewBitOut is high on every Busy cycle.

Reset
REQ-023 Reset=1 forces IDLE, divider=0, pattern=0, and DotDashOut=NewBitOut=Busy=Done=Err=0 on the next edge, mid-letter included.
REQ-024 Reset has priority over Start in the same cycle.

Configuration
REQ-025 Macro MORSE_SPEED_SEL_EN: when defined, adds input Speed[1:0], sampled on Start acceptance; the unit length becomes CLK_DIV << Speed cycles (1x, 2x, 4x, 8x).
REQ-026 Without MORSE_SPEED_SEL_EN there is no Speed port and the unit length is CLK_DIV.

Structure
REQ-027 Package morse_pkg holds MAX_CODE_W=16, LEN_W=4, NUM_LETTERS=26, the FSM state enum, and the A-Z pattern/length lookup function.
REQ-028 Sub-module morse_tick_gen holds the unit divider: synchronous clear input, tick output, and the speed shift when MORSE_SPEED_SEL_EN is defined.

Verification
REQ-029 CLK_DIV=2, Letter=0 (A, 10111), Start 1 cycle -> DotDashOut 1,1,0,0,1,1,1,1,1,1 then 6 zeros; Busy 16 cycles; Done pulse in the 17th cycle.
REQ-030 CLK_DIV=2, Letter=4 (E) -> 2 cycles high, 6 low, Done; NewBitOut pulses 4 times.
REQ-031 Letter=26 with Start -> Err pulse next cycle; Busy, DotDashOut and Done stay 0.
REQ-032 Reset asserted at cycle 5 of sending Letter=9 (J) -> all outputs 0 next cycle; a new Start then sends J from its first unit.
REQ-033 Start held high with Letter=19 (T), CLK_DIV=1 -> Busy 6 cycles, Done, 1 idle cycle, Busy again; Start pulses during Busy are ignored.
REQ-034 With MORSE_SPEED_SEL_EN, CLK_DIV=2, Speed=2'b10, Letter=4 -> 8 cycles high, 24 low, then Done.

Source files
------------

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants, FSM states and the A-Z Morse pattern lookup
package morse_pkg;

    localparam int MAX_CODE_W  = 16;
    localparam int LEN_W       = 4;
    localparam int NUM_LETTERS = 26;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    typedef struct packed {
        logic [MAX_CODE_W-1:0] pattern;
        logic [LEN_W-1:0]      len;
    } code_t;

    // Table entry: {symbol count[2:0], symbols left-aligned[3:0]}, 1 = dash.
    function automatic code_t morse_code(input logic [4:0] letter);
        logic [6:0]            t;
        logic [3:0]            sym;
        logic [MAX_CODE_W-1:0] pat;
        int                    n;
        int                    len;
        code_t                 c;
        case (letter)
            5'd0:    t = 7'b010_0100;
            5'd1:    t = 7'b100_1000;
            5'd2:    t = 7'b100_1010;
            5'd3:    t = 7'b011_1000;
            5'd4:    t = 7'b001_0000;
            5'd5:    t = 7'b100_0010;
            5'd6:    t = 7'b011_1100;
            5'd7:    t = 7'b100_0000;
            5'd8:    t = 7'b010_0000;
            5'd9:    t = 7'b100_0111;
            5'd10:   t = 7'b011_1010;
            5'd11:   t = 7'b100_0100;
            5'd12:   t = 7'b010_1100;
            5'd13:   t = 7'b010_1000;
            5'd14:   t = 7'b011_1110;
            5'd15:   t = 7'b100_0110;
            5'd16:   t = 7'b100_1101;
            5'd17:   t = 7'b011_0100;
            5'd18:   t = 7'b011_0000;
            5'd19:   t = 7'b001_1000;
            5'd20:   t = 7'b011_0010;
            5'd21:   t = 7'b100_0001;
            5'd22:   t = 7'b011_0110;
            5'd23:   t = 7'b100_1001;
            5'd24:   t = 7'b100_1011;
            5'd25:   t = 7'b100_1100;
            default: t = 7'b000_0000;
        endcase
        n   = {29'b0, t[6:4]};
        sym = t[3:0];
        pat = '0;
        len = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                if (i > 0) begin
                    pat = {pat[MAX_CODE_W-2:0], 1'b0};
                    len = len + 1;
                end
                if (sym[3]) begin
                    pat = {pat[MAX_CODE_W-4:0], 3'b111};
                    len = len + 3;
                end else begin
                    pat = {pat[MAX_CODE_W-2:0], 1'b1};
                    len = len + 1;
                end
                sym = {sym[2:0], 1'b0};
            end
        end
        c.pattern = pat << (MAX_CODE_W - len);
        c.len     = len[LEN_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// rtl/morse_tick_gen.sv - Morse unit divider; MORSE_SPEED_SEL_EN adds a sampled speed shift
module morse_tick_gen
    import morse_pkg::*;
#(
    parameter int CLK_DIV = 25_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
`ifdef MORSE_SPEED_SEL_EN
    input  logic [1:0] i_speed,
`endif
    input  logic       i_en,
    output logic       o_tick
);

    logic [31:0] r_cnt;
    logic [31:0] w_load;
    logic [31:0] w_reload;

`ifdef MORSE_SPEED_SEL_EN
    logic [31:0] r_reload;

    assign w_load   = (32'(CLK_DIV) << i_speed) - 32'd1;
    assign w_reload = r_reload;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_reload <= '0;
        else if (i_clr)
            r_reload <= w_load;
    end
`else
    assign w_load   = 32'(CLK_DIV - 1);
    assign w_reload = w_load;
`endif

    // Clear preloads a full unit so the first unit after acceptance is not short.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= w_load;
        else if (i_en)
            r_cnt <= (r_cnt == '0) ? w_reload : r_cnt - 32'd1;
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/morse_sender.sv
// rtl/morse_sender.sv - A-Z Morse letter sender; MORSE_SPEED_SEL_EN adds the Speed input
module morse_sender
    import morse_pkg::*;
#(
    parameter int CLK_DIV   = 25_000_000,
    parameter int GAP_UNITS = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
`ifdef MORSE_SPEED_SEL_EN
    input  logic [1:0] Speed,
`endif
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    state_t                r_state;
    logic [MAX_CODE_W-1:0] r_pattern;
    logic [LEN_W-1:0]      r_units;
    logic [2:0]            r_gap;
    logic                  r_dd;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    code_t                 w_code;
    logic                  w_valid;
    logic                  w_accept;
    logic                  w_en;
    logic                  w_tick;

    assign w_code   = morse_code(Letter);
    assign w_valid  = int'(Letter) < NUM_LETTERS;
    assign w_accept = (r_state == IDLE) && Start && w_valid;
    assign w_en     = (r_state == SEND) || (r_state == GAP);

    morse_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (ClockIn),
        .i_rst   (Reset),
        .i_clr   (w_accept),
`ifdef MORSE_SPEED_SEL_EN
        .i_speed (Speed),
`endif
        .i_en    (w_en),
        .o_tick  (w_tick)
    );

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_units   <= '0;
            r_gap     <= '0;
            r_dd      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        if (w_valid) begin
                            r_pattern <= w_code.pattern;
                            r_units   <= w_code.len;
                            r_dd      <= w_code.pattern[MAX_CODE_W-1];
                            r_busy    <= 1'b1;
                            r_state   <= SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_tick) begin
                        r_pattern <= r_pattern << 1;
                        r_units   <= r_units - LEN_W'(1);
                        if (r_units == LEN_W'(1)) begin
                            r_state <= GAP;
                            r_gap   <= 3'(GAP_UNITS);
                            r_dd    <= 1'b0;
                        end else begin
                            r_dd <= r_pattern[MAX_CODE_W-2];
                        end
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        if (r_gap == 3'd1) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_gap <= r_gap - 3'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DotDashOut = r_dd;
    assign NewBitOut  = w_tick;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Err        = r_err;

endmodule

// File: tb/tb_morse_sender.sv
// tb/tb_morse_sender.sv - directed self-checking bench for morse_sender (CLK_DIV=2 and CLK_DIV=1 instances)
module tb_morse_sender;

    logic       clk;
    logic       rst;
    logic       start, start1;
    logic [4:0] letter, letter1;
    logic [1:0] speed, speed1;
    logic       dd, nb, busy, done, err;
    logic       dd1, nb1, busy1, done1, err1;
    int         checks;
    int         errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    morse_sender #(.CLK_DIV(2), .GAP_UNITS(3)) dut (
        .ClockIn    (clk),
        .Reset      (rst),
        .Start      (start),
        .Letter     (letter),
`ifdef MORSE_SPEED_SEL_EN
        .Speed      (speed),
`endif
        .DotDashOut (dd),
        .NewBitOut  (nb),
        .Busy       (busy),
        .Done       (done),
        .Err        (err)
    );

    morse_sender #(.CLK_DIV(1), .GAP_UNITS(3)) dut1 (
        .ClockIn    (clk),
        .Reset      (rst),
        .Start      (start1),
        .Letter     (letter1),
`ifdef MORSE_SPEED_SEL_EN
        .Speed      (speed1),
`endif
        .DotDashOut (dd1),
        .NewBitOut  (nb1),
        .Busy       (busy1),
        .Done       (done1),
        .Err        (err1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] l, input int glitch, output logic [63:0] wave,
                        output int nbusy, output int nnb, output int ndone);
        letter = l;
        start  = 1'b1;
        step();
        start = 1'b0;
        wave  = '0;
        nbusy = 0;
        nnb   = 0;
        ndone = 0;
        for (int k = 0; k < 80 && ndone == 0; k++) begin
            if (busy) begin
                wave  = {wave[62:0], dd};
                nbusy = nbusy + 1;
            end
            if (nb) nnb = nnb + 1;
            if (done) ndone = 1;
            if (k == glitch) begin
                start  = 1'b1;
                letter = 5'd0;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    logic [63:0] wave;
    logic [15:0] tb_busy, tb_done, tb_dd;
    int          nbusy, nnb, ndone, nb1_cnt;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        letter = 5'd0; letter1 = 5'd0; speed = 2'b00; speed1 = 2'b00;
        step();
        step();
        check("reset_dd", {63'b0, dd}, 64'd0);
        check("reset_nb", {63'b0, nb}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_err", {63'b0, err}, 64'd0);
        rst = 1'b0;
        step();

        // A: 10111 at two cycles per unit, then three gap units
        send(5'd0, -1, wave, nbusy, nnb, ndone);
        check("a_wave", wave, 64'hCFC0);
        check("a_busy", 64'(nbusy), 64'd16);
        check("a_newbit", 64'(nnb), 64'd8);
        check("a_done", 64'(ndone), 64'd1);

        // Out-of-range letter
        letter = 5'd26;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("err_pulse", {60'b0, err, busy, dd, done}, 64'h8);
        step();
        check("err_clear", {60'b0, err, busy, dd, done}, 64'h0);

        // E with a Start glitch mid-letter that must be ignored
        send(5'd4, 2, wave, nbusy, nnb, ndone);
        check("e_wave", wave, 64'hC0);
        check("e_busy", 64'(nbusy), 64'd8);
        check("e_newbit", 64'(nnb), 64'd4);
        check("e_done", 64'(ndone), 64'd1);
        step();
        check("e_no_retrig", {63'b0, busy}, 64'd0);

        // J interrupted by reset at busy cycle 5
        letter = 5'd9;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("j_busy_c5", {62'b0, busy, dd}, 64'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("j_reset", {59'b0, dd, nb, busy, done, err}, 64'h0);
        send(5'd9, -1, wave, nbusy, nnb, ndone);
        check("j_wave", wave, 64'hCFCFCFC0);
        check("j_busy", 64'(nbusy), 64'd32);
        check("j_newbit", 64'(nnb), 64'd16);

        // Reset wins over Start in the same cycle
        rst    = 1'b1;
        start  = 1'b1;
        letter = 5'd4;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio", {63'b0, busy}, 64'd0);
        step();

        // T held with CLK_DIV=1: back-to-back letters, one idle cycle between
        letter1 = 5'd19;
        start1  = 1'b1;
        step();
        tb_busy = '0;
        tb_done = '0;
        tb_dd   = '0;
        nb1_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tb_busy = {tb_busy[14:0], busy1};
            tb_done = {tb_done[14:0], done1};
            tb_dd   = {tb_dd[14:0], dd1};
            if (nb1) nb1_cnt = nb1_cnt + 1;
            step();
        end
        start1 = 1'b0;
        check("t_busy", 64'(tb_busy), 64'hFCFC);
        check("t_done", 64'(tb_done), 64'h0202);
        check("t_wave", 64'(tb_dd), 64'hE0E0);
        check("t_newbit", 64'(nb1_cnt), 64'd12);

`ifdef MORSE_SPEED_SEL_EN
        for (int k = 0; k < 12; k++) step();
        speed = 2'b10;
        send(5'd4, -1, wave, nbusy, nnb, ndone);
        check("spd_wave", wave, 64'hFF000000);
        check("spd_busy", 64'(nbusy), 64'd32);
        check("spd_done", 64'(ndone), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
